alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-driven controller that sits in front of the 16-bit combinational ALU. It accepts operation commands over a valid/ready handshake, reads operands from an internal 8×16 register file, and drives the ALU operand, opcode and carry-in ports. It captures the ALU result and status, then writes the result back and updates a persistent flags register. The flags register's carry bit feeds the ALU carry-in for ADC/SBB/RCL/RCR.

## Interface
Parameters:
- REG_ADDR_W, 3: register index width; register file depth is 2**REG_ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  5  ALU opcode; 5'b00000 = LDI (load immediate).
- cmd_rd  in  REG_ADDR_W  destination register.
- cmd_ra  in  REG_ADDR_W  operand A register.
- cmd_rb  in  REG_ADDR_W  operand B register.
- cmd_imm  in  16  immediate, used by LDI only.
- alu_a, alu_b  out  16  ALU operands.
- alu_f  out  5  ALU opcode.
- alu_cin  out  1  ALU carry-in.
- alu_result  in  16  ALU result (combinational from alu_* outputs).
- alu_status  in  6  ALU status, bit order {CF,ZF,NF,VF,PF,AF} = [5:0].
- flags  out  6  registered flags, same bit order.
- done  out  1  one-cycle pulse: command retired.
- err  out  1  one-cycle pulse: illegal opcode retired.
- dbg_addr  in  REG_ADDR_W  debug read index.
- dbg_data  out  16  combinational read of regfile[dbg_addr].

## Operation
- Legal opcodes:
  - LDI 00000.
  - Arithmetic: INC 00001, DEC 00011, ADD 00100, ADC 00101, SUB 00110, SBB 00111.
  - Logic: AND 01000, OR 01001, XOR 01010, NOT 01011.
  - Shift/rotate: SHL 10000, SHR 10001, SAL 10010, SAR 10011, ROL 10100, ROR 10101, RCL 10110, RCR 10111.
  - All other codes are illegal.
- FSM states:
  - IDLE: cmd_ready=1. cmd_valid=1 accepts the command, latches op/rd/ra/rb/imm, and moves to EXEC.
  - EXEC: cmd_ready=0.
    - ALU is driven with alu_a=regfile[ra], alu_b=regfile[rb], alu_f=op, alu_cin=flags[5].
    - At the end of the cycle the command retires (see retire rules), done or err is registered, and the FSM returns to IDLE.
- Outside EXEC: alu_a, alu_b, alu_f, alu_cin are driven to 0.
- Retire rules:
  - LDI: regfile[rd] <= imm; flags unchanged; done=1.
  - Legal ALU op: regfile[rd] <= alu_result; done=1. Flags update:
    - ZF, NF, PF always from alu_status.
    - CF from alu_status for arithmetic and shift/rotate ops; retained for logic ops.
    - VF and AF from alu_status for arithmetic ops only; retained otherwise.
  - Illegal op: no register write, flags unchanged, err=1, done=0.
- Operands are read in EXEC, so a command sees the write-back of the immediately preceding command.
- rd may equal ra/rb. The write occurs at the retire edge, after the operands have been used.
- ALU X bits on flags the block does not update must never reach the flags register.

## Timing
- Reset values: state IDLE, all registers 0x0000, flags 6'b0, done 0, err 0, cmd_ready 1, alu_* outputs 0.
- Accept at edge N. EXEC occupies cycle N→N+1. Retire at edge N+1, with done/err high during cycle N+1→N+2.
- cmd_ready returns to 1 in the same cycle done is high.
- Maximum throughput is one command per 2 cycles. cmd_valid held high with changing fields yields a retire every 2 cycles.
- Results are visible on dbg_data, and flags on flags, from edge N+1.
- cmd_valid while cmd_ready=0 is ignored. The source must hold the command until it observes ready.
- rst asserted during EXEC: the in-flight command is discarded with no write, no flag change and no done; all state goes to reset values at that edge.
- rst wins over a simultaneous accept.

## Test plan
- Reset, then LDI r1=0x7FFF, LDI r2=0x0001, ADD r3=r1,r2 -> r3=0x8000; flags CF=0 ZF=0 NF=1 VF=1 PF=0 AF=1; done high one cycle each, 2 cycles apart.
- LDI r1=0xFFFF, ADD r3=r1,r1, then ADC r4=r0,r0 -> r3=0xFFFE with CF=1; during the ADC EXEC alu_cin=1; r4=0x0001; final CF=0, ZF=0.
- After the first scenario, AND r5=r1,r2 -> r5=0x0001; ZF=0 NF=0 PF=0 updated; CF=0 VF=1 AF=1 retained.
- Illegal op 5'b01100 with rd=r1 -> err pulse, done=0, r1 and flags unchanged; the next legal command proceeds normally.
- Assert rst in the EXEC cycle of ADD r3=r1,r2 -> r3 stays 0x0000, flags 0, no done; cmd_ready=1 after the reset edge.
- cmd_valid held high for 4 consecutive commands -> exactly 4 done pulses at cycles N+1, N+3, N+5, N+7; cmd_ready toggles 1/0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a 16-bit combinational ALU: it accepts one command,
// spends one EXEC cycle driving the ALU, then writes back the result and updates the flags.
module alu_cmd_sequencer #(
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [4:0]            cmd_op,
   input  logic [REG_ADDR_W-1:0] cmd_rd,
   input  logic [REG_ADDR_W-1:0] cmd_ra,
   input  logic [REG_ADDR_W-1:0] cmd_rb,
   input  logic [15:0]           cmd_imm,
   output logic [15:0]           alu_a,
   output logic [15:0]           alu_b,
   output logic [4:0]            alu_f,
   output logic                  alu_cin,
   input  logic [15:0]           alu_result,
   input  logic [5:0]            alu_status,
   output logic [5:0]            flags,
   output logic                  done,
   output logic                  err,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [15:0]           dbg_data
);

   localparam int DEPTH = 2 ** REG_ADDR_W;
   localparam logic [4:0] OP_LDI = 5'b00000;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t                  state_reg, state_next;
   logic [4:0]              op_reg;
   logic [REG_ADDR_W-1:0]   rd_reg, ra_reg, rb_reg;
   logic [15:0]             imm_reg;
   logic [15:0]             regfile [DEPTH];
   logic [5:0]              flags_reg, flags_next;
   logic                    done_reg, done_next;
   logic                    err_reg, err_next;
   logic                    wr_en;
   logic [15:0]             wr_data;

   logic is_arith, is_logic, is_shift, is_legal;

   always_comb begin
      is_arith = (op_reg == 5'b00001) || (op_reg == 5'b00011) || (op_reg[4:2] == 3'b001);
      is_logic = (op_reg[4:2] == 3'b010);
      is_shift = (op_reg[4:3] == 2'b10);
      is_legal = (op_reg == OP_LDI) || is_arith || is_logic || is_shift;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         op_reg    <= '0;
         rd_reg    <= '0;
         ra_reg    <= '0;
         rb_reg    <= '0;
         imm_reg   <= '0;
         flags_reg <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         flags_reg <= flags_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
         if (state_reg == IDLE && cmd_valid) begin
            op_reg  <= cmd_op;
            rd_reg  <= cmd_rd;
            ra_reg  <= cmd_ra;
            rb_reg  <= cmd_rb;
            imm_reg <= cmd_imm;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
      end else if (wr_en) begin
         regfile[rd_reg] <= wr_data;
      end
   end

   // Status bits are only sampled into flags for the op classes that define them,
   // so undefined ALU outputs never leak into the retained bits.
   always_comb begin
      state_next = state_reg;
      flags_next = flags_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
      wr_en      = 1'b0;
      wr_data    = imm_reg;
      cmd_ready  = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_f      = '0;
      alu_cin    = 1'b0;
      case (state_reg)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_next = EXEC;
         end
         EXEC: begin
            alu_a      = regfile[ra_reg];
            alu_b      = regfile[rb_reg];
            alu_f      = op_reg;
            alu_cin    = flags_reg[5];
            state_next = IDLE;
            if (!is_legal) begin
               err_next = 1'b1;
            end else begin
               done_next = 1'b1;
               wr_en     = 1'b1;
               if (op_reg != OP_LDI) begin
                  wr_data       = alu_result;
                  flags_next[4] = alu_status[4];
                  flags_next[3] = alu_status[3];
                  flags_next[1] = alu_status[1];
                  if (is_arith || is_shift) flags_next[5] = alu_status[5];
                  if (is_arith) begin
                     flags_next[2] = alu_status[2];
                     flags_next[0] = alu_status[0];
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign flags    = flags_reg;
   assign done     = done_reg;
   assign err      = err_reg;
   assign dbg_data = regfile[dbg_addr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural ALU drives alu_result/alu_status, and a
// command-level model of the sequencer is compared against the DUT every cycle.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_op;
   logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
   logic [15:0] cmd_imm;
   logic [15:0] alu_a, alu_b;
   logic [4:0]  alu_f;
   logic        alu_cin;
   logic [15:0] alu_result;
   logic [5:0]  alu_status;
   logic [5:0]  flags;
   logic        done, err;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int vectors = 0;
   int miscompares = 0;
   bit started = 0;
   bit rand_dbg = 0;
   int cycle = 0;
   int done_total = 0;
   int done_cycles[$];
   logic [21:0] junk = '0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.REG_ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_status(alu_status), .flags(flags),
      .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Reference ALU; status/result bits an op leaves undefined come from junk.
   function automatic logic [21:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] f, input logic cin,
                                          input logic [21:0] jk);
      logic [16:0] w;
      logic [15:0] r;
      logic cf, vf, af, c;
      r  = jk[15:0];
      cf = jk[21];
      vf = jk[18];
      af = jk[16];
      c  = (f == 5'd5 || f == 5'd7) ? cin : 1'b0;
      case (f)
         5'd1: begin w = {1'b0, a} + 17'd1; r = w[15:0]; cf = w[16];
            vf = (a == 16'h7FFF); af = (a[3:0] == 4'hF); end
         5'd3: begin r = a - 16'd1; cf = (a == 16'h0000);
            vf = (a == 16'h8000); af = (a[3:0] == 4'h0); end
         5'd4, 5'd5: begin w = {1'b0, a} + {1'b0, b} + {16'b0, c}; r = w[15:0]; cf = w[16];
            vf = (a[15] == b[15]) && (r[15] != a[15]);
            af = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c}) > 5'd15; end
         5'd6, 5'd7: begin w = {1'b0, a} - {1'b0, b} - {16'b0, c}; r = w[15:0]; cf = w[16];
            vf = (a[15] != b[15]) && (r[15] != a[15]);
            af = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'b0, c}); end
         5'd8:  r = a & b;
         5'd9:  r = a | b;
         5'd10: r = a ^ b;
         5'd11: r = ~a;
         5'd16, 5'd18: begin r = {a[14:0], 1'b0}; cf = a[15]; end
         5'd17: begin r = {1'b0, a[15:1]}; cf = a[0]; end
         5'd19: begin r = {a[15], a[15:1]}; cf = a[0]; end
         5'd20: begin r = {a[14:0], a[15]}; cf = a[15]; end
         5'd21: begin r = {a[0], a[15:1]}; cf = a[0]; end
         5'd22: begin r = {a[14:0], cin}; cf = a[15]; end
         5'd23: begin r = {cin, a[15:1]}; cf = a[0]; end
         default: ;
      endcase
      return {cf, (r == 16'h0000), r[15], vf, ~^r, af, r};
   endfunction

   always_comb {alu_status, alu_result} = alu_fn(alu_a, alu_b, alu_f, alu_cin, junk);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Sequencer model: register array, flags, and at most one in-flight command.
   logic [15:0] m_regs [8];
   logic [5:0]  m_flags;
   bit          m_busy, m_done, m_err;
   logic [4:0]  p_op;
   logic [2:0]  p_rd, p_ra, p_rb;
   logic [15:0] p_imm;

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_flags = '0; m_busy = 0; m_done = 0; m_err = 0;
      p_op = '0; p_rd = '0; p_ra = '0; p_rb = '0; p_imm = '0;
   end

   always begin : compare_proc
      logic [15:0] n_regs [8];
      logic [5:0]  n_flags, st;
      logic [21:0] res;
      bit n_busy, n_done, n_err, arith, logic_op, shift_op;
      @(negedge clk);
      if (started) begin
         chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("err", 32'(err), 32'(m_err));
         chk("flags", 32'(flags), 32'(m_flags));
         chk("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
         chk("alu_a", 32'(alu_a), m_busy ? 32'(m_regs[p_ra]) : 32'd0);
         chk("alu_b", 32'(alu_b), m_busy ? 32'(m_regs[p_rb]) : 32'd0);
         chk("alu_f", 32'(alu_f), m_busy ? 32'(p_op) : 32'd0);
         chk("alu_cin", 32'(alu_cin), m_busy ? 32'(m_flags[5]) : 32'd0);
         if (done === 1'b1) begin
            done_total++;
            done_cycles.push_back(cycle);
         end
      end
      n_regs = m_regs; n_flags = m_flags; n_busy = m_busy; n_done = 0; n_err = 0;
      arith    = p_op inside {5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
      logic_op = p_op inside {5'd8, 5'd9, 5'd10, 5'd11};
      shift_op = p_op inside {[5'd16:5'd23]};
      if (rst) begin
         for (int i = 0; i < 8; i++) n_regs[i] = '0;
         n_flags = '0; n_busy = 0;
      end else if (m_busy) begin
         n_busy = 0;
         if (p_op == 5'd0) begin
            n_regs[p_rd] = p_imm; n_done = 1;
         end else if (arith || logic_op || shift_op) begin
            res = alu_fn(m_regs[p_ra], m_regs[p_rb], p_op, m_flags[5], 22'd0);
            st = res[21:16];
            n_regs[p_rd] = res[15:0];
            n_done = 1;
            n_flags[4] = st[4]; n_flags[3] = st[3]; n_flags[1] = st[1];
            if (!logic_op) n_flags[5] = st[5];
            if (arith) begin n_flags[2] = st[2]; n_flags[0] = st[0]; end
         end else begin
            n_err = 1;
         end
      end else if (cmd_valid) begin
         n_busy = 1;
         p_op = cmd_op; p_rd = cmd_rd; p_ra = cmd_ra; p_rb = cmd_rb; p_imm = cmd_imm;
      end
      @(posedge clk);
      m_regs = n_regs; m_flags = n_flags; m_busy = n_busy; m_done = n_done; m_err = n_err;
      cycle++;
      #3 junk = {$urandom, $urandom}[21:0];
      if (rand_dbg) dbg_addr = 3'($urandom_range(0, 7));
   end

   // Presents a command with cmd_valid high and returns #1 after the accepting edge.
   task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [15:0] imm);
      bit acc;
      int n;
      cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
      acc = 0; n = 0;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic peek(input string name, input logic [2:0] addr, input logic [15:0] exp);
      dbg_addr = addr;
      #1;
      chk(name, 32'(dbg_data), 32'(exp));
   endtask

   logic [4:0] legal_ops [24];
   int d0;

   initial begin
      legal_ops = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                    5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                    5'd0, 5'd4, 5'd5, 5'd7, 5'd22};
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
      cmd_imm = '0; dbg_addr = '0;
      tick(2);
      started = 1;
      rst = 1'b0;
      chk("reset_ready", 32'(cmd_ready), 32'd1);
      chk("reset_flags", 32'(flags), 32'd0);
      chk("reset_alu_a", 32'(alu_a), 32'd0);
      peek("reset_r7", 3'd7, 16'h0000);

      // LDI, LDI, ADD with cmd_valid held high
      issue(5'd0, 3'd1, 3'd0, 3'd0, 16'h7FFF);
      issue(5'd0, 3'd2, 3'd0, 3'd0, 16'h0001);
      issue(5'd4, 3'd3, 3'd1, 3'd2, 16'h0000);
      cmd_valid = 1'b0;
      tick(1);
      chk("add_done", 32'(done), 32'd1);
      chk("add_flags", 32'(flags), 32'(6'b001101));
      peek("add_r3", 3'd3, 16'h8000);

      issue(5'd8, 3'd5, 3'd1, 3'd2, 16'h0000);
      cmd_valid = 1'b0;
      tick(1);
      chk("and_flags", 32'(flags), 32'(6'b000101));
      peek("and_r5", 3'd5, 16'h0001);

      issue(5'b01100, 3'd1, 3'd2, 3'd2, 16'h1234);
      cmd_valid = 1'b0;
      tick(1);
      chk("illegal_err", 32'(err), 32'd1);
      chk("illegal_done", 32'(done), 32'd0);
      chk("illegal_flags", 32'(flags), 32'(6'b000101));
      peek("illegal_r1", 3'd1, 16'h7FFF);

      issue(5'd0, 3'd1, 3'd0, 3'd0, 16'hFFFF);
      issue(5'd4, 3'd3, 3'd1, 3'd1, 16'h0000);
      issue(5'd5, 3'd4, 3'd0, 3'd0, 16'h0000);
      cmd_valid = 1'b0;
      chk("adc_cin", 32'(alu_cin), 32'd1);
      tick(1);
      chk("adc_cf_zf", 32'(flags[5:4]), 32'd0);
      peek("adc_r4", 3'd4, 16'h0001);
      peek("add_ffff_r3", 3'd3, 16'hFFFE);

      // reset during the EXEC cycle
      issue(5'd0, 3'd1, 3'd0, 3'd0, 16'h7FFF);
      issue(5'd4, 3'd3, 3'd1, 3'd1, 16'h0000);
      cmd_valid = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_exec_done", 32'(done), 32'd0);
      chk("rst_exec_ready", 32'(cmd_ready), 32'd1);
      chk("rst_exec_flags", 32'(flags), 32'd0);
      peek("rst_exec_r3", 3'd3, 16'h0000);

      // four back-to-back commands
      tick(1);
      d0 = done_total;
      done_cycles.delete();
      for (int k = 0; k < 4; k++) issue(5'd0, 3'(k), 3'd0, 3'd0, 16'(k * 16'h1111 + 16'h0101));
      cmd_valid = 1'b0;
      tick(3);
      chk("burst_done_count", 32'(done_total - d0), 32'd4);
      for (int k = 1; k < done_cycles.size(); k++)
         chk("burst_done_spacing", 32'(done_cycles[k] - done_cycles[k-1]), 32'd2);
      peek("burst_r3", 3'd3, 16'h3434);

      // randomized phase
      rand_dbg = 1;
      for (int t = 0; t < 400; t++) begin
         logic [4:0] op;
         if ($urandom_range(0, 3) == 0) begin
            cmd_valid = 1'b0;
            tick($urandom_range(1, 2));
         end
         op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 23)];
         issue(op, 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
         if ($urandom_range(0, 39) == 0) begin
            cmd_valid = 1'b0;
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      tick(4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
